// File: rtl/inv_chain_freq_meter.sv
// ---------------------------------------------------------------------------
// inv_chain_freq_meter
//
// Measurement companion for the analog inverter-chain test structures.
// A programmable divider produces a square-wave stimulus for the chain input.
// One of NUM_CH digitised chain outputs is resynchronised and its edges are
// counted over a gate window of G clock cycles. A saturating count is
// returned with a busy/done handshake.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        block enable; low aborts any measurement and holds IDLE
//   ch_in      asynchronous digitised inverter outputs, one bit per channel
//   ch_sel     channel to measure (latched on start)
//   edge_mode  00 rise, 01 fall, 10 both, 11 rise (latched on start)
//   gate_len   gate window length in clk cycles (latched on start)
//   start      level request, only sampled while IDLE
//   stim_en    stimulus divider enable
//   stim_div   stimulus toggles every stim_div+1 cycles
//   stim_out   stimulus to the inverter chain input
//   busy       high during ARM and COUNT
//   done       one-cycle pulse, result/overflow valid
//   result     last completed count, held until the next done
//   overflow   counter saturated during the last measurement
//
// Timing, with start accepted in cycle T and gate length G:
//   ARM   cycles T+1, T+2
//   COUNT cycles T+3 .. T+2+G
//   DONE  cycle  T+3+G   (T+1 when G==0)
// ---------------------------------------------------------------------------
module inv_chain_freq_meter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_CH-1:0]         ch_in,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  input  logic [1:0]                edge_mode,
  input  logic [GATE_W-1:0]         gate_len,
  input  logic                      start,
  input  logic                      stim_en,
  input  logic [7:0]                stim_div,
  output logic                      stim_out,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          result,
  output logic                      overflow
);

  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM1  = 3'd1,
    ST_ARM2  = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Saturating increment: returns {saturated, next_value}. At all-ones the
  // value holds and the saturation bit is raised.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v)
      sat_inc = {1'b1, v};
    else
      sat_inc = {1'b0, v + 1'b1};
  endfunction

  // Edge qualification of the selected channel against its previous value.
  function automatic logic edge_hit(input logic       cur,
                                    input logic       prev,
                                    input logic [1:0] mode);
    case (mode)
      2'b01:   edge_hit = prev & ~cur;
      2'b10:   edge_hit = prev ^ cur;
      default: edge_hit = cur & ~prev;
    endcase
  endfunction

  state_t               state_q;
  logic [SEL_W-1:0]     ch_q;
  logic [1:0]           mode_q;
  logic [GATE_W-1:0]    gate_cnt_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;

  logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
  logic                 sel_p0;
  logic                 prev_p1;
  logic                 edge_p1;

  logic [CNT_W:0]       sat_p1;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 ovf_nxt;

  logic [7:0]           div_cnt_q;
  logic [7:0]           div_q;

  // ---- stage p0: synchronisers, free-running on every channel -------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ch_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  // Explicit decode keeps an out-of-range selection (non power-of-two
  // NUM_CH) reading as a constant low instead of an undefined bit.
  always_comb begin
    sel_p0 = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_q == SEL_W'(i))
        sel_p0 = sync_q[SYNC_STAGES-1][i];
  end

  // ---- stage p1: registered edge detect -----------------------------------
  // prev_p1 tracks the selected bit every cycle, so by the second ARM cycle
  // the history already belongs to the newly latched channel. The compare
  // made in the first ARM cycle mixes old and new channels and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_p1 <= 1'b0;
      edge_p1 <= 1'b0;
    end else begin
      prev_p1 <= sel_p0;
      edge_p1 <= (state_q == ST_ARM1) ? 1'b0 : edge_hit(sel_p0, prev_p1, mode_q);
    end
  end

  always_comb begin
    sat_p1  = sat_inc(cnt_q);
    cnt_nxt = cnt_q;
    ovf_nxt = ovf_q;
    if (edge_p1) begin
      cnt_nxt = sat_p1[CNT_W-1:0];
      ovf_nxt = ovf_q | sat_p1[CNT_W];
    end
  end

  // ---- stage p2: measurement FSM, counter and result registers ------------
  // result/overflow load from cnt_nxt so the edge seen in the final COUNT
  // cycle is included on the same edge that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      mode_q     <= 2'b00;
      gate_cnt_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else if (!ena) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ch_q       <= ch_sel;
            mode_q     <= edge_mode;
            gate_cnt_q <= gate_len;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            if (gate_len == '0) begin
              state_q  <= ST_DONE;
              done     <= 1'b1;
              result   <= '0;
              overflow <= 1'b0;
            end else begin
              state_q <= ST_ARM1;
              busy    <= 1'b1;
            end
          end
        end
        ST_ARM1: begin
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= ST_ARM2;
        end
        ST_ARM2: begin
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          state_q <= ST_COUNT;
        end
        ST_COUNT: begin
          cnt_q <= cnt_nxt;
          ovf_q <= ovf_nxt;
          if (gate_cnt_q == GATE_W'(1)) begin
            state_q  <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= cnt_nxt;
            overflow <= ovf_nxt;
          end else begin
            gate_cnt_q <= gate_cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // ---- stimulus divider ---------------------------------------------------
  // div_q captures stim_div only at a wrap (or while disabled), so a new
  // divide ratio never truncates or stretches the half-period in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= 8'd0;
      div_q     <= 8'd0;
      stim_out  <= 1'b0;
    end else if (!stim_en) begin
      div_cnt_q <= 8'd0;
      div_q     <= stim_div;
    end else if (div_cnt_q == div_q) begin
      div_cnt_q <= 8'd0;
      div_q     <= stim_div;
      stim_out  <= ~stim_out;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_inv_chain_freq_meter.sv
module tb_inv_chain_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  ch_in;
  logic [1:0]  ch_sel;
  logic [1:0]  edge_mode;
  logic [15:0] gate_len;
  logic        start;
  logic        stim_en;
  logic [7:0]  stim_div;
  logic        stim_out;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic        ch_a, ch_b, ch_d;

  // Narrow-counter instance for saturation
  logic        ena4, start4;
  logic [3:0]  ch_in4;
  logic [15:0] gate_len4;
  logic        stim_out4, busy4, done4, overflow4;
  logic [3:0]  result4;
  logic        ch4_bit = 1'b0;
  int          ph4 = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] hist [0:8191];

  // loopback: stimulus drives channel 2
  assign ch_in  = {ch_d, stim_out, ch_b, ch_a};
  assign ch_in4 = {3'b000, ch4_bit};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // period-4 square wave, 2 high / 2 low
  always @(posedge clk) begin
    ph4     <= (ph4 == 3) ? 0 : ph4 + 1;
    ch4_bit <= (ph4 >= 2);
  end

  inv_chain_freq_meter #(.NUM_CH(4), .CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ch_in(ch_in), .ch_sel(ch_sel),
    .edge_mode(edge_mode), .gate_len(gate_len), .start(start),
    .stim_en(stim_en), .stim_div(stim_div), .stim_out(stim_out),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  inv_chain_freq_meter #(.NUM_CH(4), .CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .ch_in(ch_in4), .ch_sel(2'd0),
    .edge_mode(2'b00), .gate_len(gate_len4), .start(start4),
    .stim_en(1'b0), .stim_div(8'd0), .stim_out(stim_out4),
    .busy(busy4), .done(done4), .result(result4), .overflow(overflow4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Input change first visible in cycle j is counted when T <= j <= T+G-1.
  function automatic int model_count(input int t0, input int g, input int ch,
                                     input logic [1:0] mode);
    int n = 0;
    for (int j = t0; j < t0 + g; j++) begin
      logic a, b;
      a = hist[j-1][ch];
      b = hist[j][ch];
      case (mode)
        2'b01:   if (a && !b) n++;
        2'b10:   if (a != b)  n++;
        default: if (!a && b) n++;
      endcase
    end
    return n;
  endfunction

  int         m_bs = 1, m_be = 0, m_done_at = -1;
  int         m_t = 0, m_g = 0, m_ch = 0;
  logic [1:0] m_mode = 2'b00;
  int         m_result = 0;
  logic       m_ovf = 1'b0;

  always @(negedge clk) begin
    logic exp_busy, exp_done;
    int   n;
    if (cyc < 8192) hist[cyc] = ch_in;
    if (!rst_n) begin
      m_bs = 1; m_be = 0; m_done_at = -1; m_result = 0; m_ovf = 1'b0;
    end else begin
      if (cyc == m_done_at) begin
        n = (m_g == 0) ? 0 : model_count(m_t, m_g, m_ch, m_mode);
        if (n > 65535) begin m_result = 65535; m_ovf = 1'b1; end
        else begin m_result = n; m_ovf = 1'b0; end
      end
      exp_busy = (cyc >= m_bs) && (cyc <= m_be);
      exp_done = (cyc == m_done_at);
      chk("model_busy", busy, exp_busy);
      chk("model_done", done, exp_done);
      chk("model_result", result, m_result);
      chk("model_overflow", overflow, m_ovf);
      if (!ena) begin
        if (m_be >= cyc) m_be = cyc;
        if (m_done_at > cyc) m_done_at = -1;
      end else if (!exp_busy && !exp_done && start) begin
        m_t = cyc; m_g = gate_len; m_ch = ch_sel; m_mode = edge_mode;
        if (gate_len == 16'd0) begin
          m_bs = 1; m_be = 0; m_done_at = cyc + 1;
        end else begin
          m_bs = cyc + 1; m_be = cyc + 2 + gate_len; m_done_at = cyc + 3 + gate_len;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_meas(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [15:0] g, output int t);
    @(posedge clk); #1;
    ch_sel = ch; edge_mode = mode; gate_len = g; start = 1'b1; t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dcyc,
                           output logic [15:0] res, output logic ovf);
    dcyc = -1; res = '0; ovf = 1'b0;
    for (int i = 0; i < limit && dcyc < 0; i++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; res = result; ovf = overflow; end
    end
  endtask

  task automatic toggle_gap(output int gap);
    logic lv;
    int   c1;
    c1 = -1; gap = -1;
    @(negedge clk); lv = stim_out;
    for (int i = 0; i < 600 && c1 < 0; i++) begin
      @(negedge clk);
      if (stim_out != lv) begin c1 = cyc; lv = stim_out; end
    end
    if (c1 >= 0)
      for (int i = 0; i < 600 && gap < 0; i++) begin
        @(negedge clk);
        if (stim_out != lv) gap = cyc - c1;
      end
  endtask

  task automatic run4(input logic [15:0] g, input int exp_res, input logic exp_ovf);
    int t, dc;
    logic [3:0] r;
    logic o;
    @(posedge clk); #1;
    gate_len4 = g; start4 = 1'b1; t = cyc;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("sat_busy", busy4, 1'b1);
    dc = -1; r = '0; o = 1'b0;
    for (int i = 0; i < 300 && dc < 0; i++) begin
      @(negedge clk);
      if (done4) begin dc = cyc; r = result4; o = overflow4; end
    end
    chk("sat_done_cycle", dc, t + 3 + g);
    chk("sat_result", r, exp_res);
    chk("sat_overflow", o, exp_ovf);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t, dc, gap, nd, nchg;
    logic [15:0] r;
    logic o, lv;

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; ch_sel = 2'd0; edge_mode = 2'b00;
    gate_len = 16'd0; stim_en = 1'b0; stim_div = 8'd3;
    ch_a = 1'b0; ch_b = 1'b0; ch_d = 1'b1;
    ena4 = 1'b1; start4 = 1'b0; gate_len4 = 16'd0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 16'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_stim_out", stim_out, 1'b0);
    #1 rst_n = 1'b1;

    // stimulus period 8 (toggle every 4)
    @(posedge clk); #1 stim_en = 1'b1;
    toggle_gap(gap);
    chk("stim_gap_div3", gap, 4);

    // loopback, rising edges, G=64
    start_meas(2'd2, 2'b00, 16'd64, t);
    wait_done(120, dc, r, o);
    chk("lb_rise_done_cycle", dc, t + 67);
    chk("lb_rise_result", r, 16'd8);
    chk("lb_rise_overflow", o, 1'b0);

    start_meas(2'd2, 2'b10, 16'd64, t);
    wait_done(120, dc, r, o);
    chk("lb_both_done_cycle", dc, t + 67);
    chk("lb_both_result", r, 16'd16);

    start_meas(2'd2, 2'b01, 16'd64, t);
    wait_done(120, dc, r, o);
    chk("lb_fall_result", r, 16'd8);

    // restart request and parameter changes while busy are ignored
    start_meas(2'd2, 2'b00, 16'd64, t);
    repeat (30) @(posedge clk);
    #1 start = 1'b1; ch_sel = 2'd0; gate_len = 16'd5; edge_mode = 2'b10;
    @(posedge clk); #1 start = 1'b0;
    nd = 0; r = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin nd++; r = result; end
    end
    chk("restart_single_done", nd, 1);
    chk("restart_result", r, 16'd8);

    // ena dropped at T+20
    start_meas(2'd2, 2'b00, 16'd64, t);
    repeat (19) @(posedge clk);
    #1 ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ena_drop_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
    wait_done(100, dc, r, o);
    chk("ena_drop_no_done", dc, -1);
    chk("ena_drop_result_held", result, 16'd8);

    // zero-length gate
    start_meas(2'd2, 2'b00, 16'd0, t);
    wait_done(10, dc, r, o);
    chk("g0_done_cycle", dc, t + 1);
    chk("g0_result", r, 16'd0);
    chk("g0_busy", busy, 1'b0);

    // async reset mid-COUNT, with a nonzero result from a prior run
    start_meas(2'd2, 2'b00, 16'd32, t);
    wait_done(60, dc, r, o);
    chk("pre_rst_result", r, 16'd4);
    start_meas(2'd2, 2'b00, 16'd64, t);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_result", result, 16'd0);
    chk("arst_stim_out", stim_out, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    start_meas(2'd2, 2'b00, 16'd0, t);
    wait_done(10, dc, r, o);
    chk("post_rst_idle_start", dc, t + 1);

    // stim_div=0: toggles every cycle
    @(posedge clk); #1 stim_div = 8'd0;
    toggle_gap(gap);
    chk("stim_gap_div0", gap, 1);

    // stim_en=0 freezes stim_out
    @(posedge clk); #1 stim_en = 1'b0;
    @(negedge clk); lv = stim_out; nchg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stim_out != lv) nchg++;
    end
    chk("stim_frozen", nchg, 0);

    // 4-bit counter: 25 edges saturate, 10 edges do not
    run4(16'd100, 15, 1'b1);
    run4(16'd40, 10, 1'b0);
    chk("sat_stim_idle", stim_out4, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
